// File: rtl/walk_pkg.sv
// Shared definitions for the crosswalk request controller: phase state
// encoding, default timing and the round-robin grant search.
package walk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WALK  = 2'd1,
    ST_FLASH = 2'd2,
    ST_CLEAR = 2'd3
  } walk_state_t;

  localparam int unsigned DEF_DEBOUNCE  = 4;
  localparam int unsigned DEF_WALK_CYC  = 8;
  localparam int unsigned DEF_FLASH_CYC = 4;
  localparam int unsigned MAX_CH        = 8;

  // First set bit of req strictly after 'last', wrapping within n channels.
  // Returns 'last' when nothing is requested; callers only use the result
  // when at least one request is present.
  function automatic logic [2:0] rr_next_grant(input logic [7:0] req,
                                               input logic [2:0] last,
                                               input int unsigned n);
    logic [2:0]  g;
    logic        found;
    logic        hit;
    int unsigned idx;
    g     = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      idx   = (32'(last) + k) % n;
      hit   = !found && (k <= n) && req[idx[2:0]];
      g     = hit ? idx[2:0] : g;
      found = found | hit;
    end
    return g;
  endfunction

endpackage

// File: rtl/walk_request_ctrl_btn_debounce.sv
// One pedestrian button: two-flop synchroniser, saturating debounce counter
// and a single-cycle press pulse on the edge the debounced level rises.
module btn_debounce #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             s1_r;
  logic             s2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             db_r;

  // Bring the asynchronous pad into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= btn;
      s2_r <= s1_r;
    end
  end

  // Count consecutive synchronised-high cycles; the level is accepted on the
  // edge the count reaches DEBOUNCE and dropped as soon as the input falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
      db_r  <= 1'b0;
    end else if (s2_r) begin
      if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (cnt_r == CNT_LAST) begin
        db_r <= 1'b1;
      end else begin
        db_r <= db_r;
      end
    end else begin
      cnt_r <= {CNT_W{1'b0}};
      db_r  <= 1'b0;
    end
  end

  // The pulse coincides with the edge where db rises, so the request latch
  // sets on that same edge; the counter saturates so a held button fires once.
  assign press = s2_r && !db_r && (cnt_r == CNT_LAST);

endmodule

// File: rtl/walk_request_ctrl.sv
// Multi-channel crosswalk request controller: debounced sticky requests,
// round-robin arbitration and one WALK / FLASH / CLEAR phase per grant.
module walk_request_ctrl
  import walk_pkg::*;
#(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned DEBOUNCE  = DEF_DEBOUNCE,
  parameter int unsigned WALK_CYC  = DEF_WALK_CYC,
  parameter int unsigned FLASH_CYC = DEF_FLASH_CYC,
  parameter int unsigned CNT_W     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic            svc_ready,
  output logic [N_CH-1:0] walk,
  output logic [N_CH-1:0] flash,
  output logic [N_CH-1:0] pending,
  output logic            busy
);

  localparam int unsigned      GW         = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  walk_state_t      state_r,   state_s;
  logic [CNT_W-1:0] phase_r,   phase_s;
  logic [GW-1:0]    grant_r,   grant_s;
  logic [GW-1:0]    rr_r,      rr_s;
  logic [N_CH-1:0]  pending_r, pending_s;
  logic [N_CH-1:0]  walk_r,    walk_s;
  logic [N_CH-1:0]  flash_r,   flash_s;
  logic             busy_r,    busy_s;
  logic [N_CH-1:0]  clr_s;
  logic [N_CH-1:0]  press_s;
  logic [GW-1:0]    pick_s;
  logic [N_CH-1:0]  pick_oh_s;
  logic [N_CH-1:0]  grant_oh_s;
  logic [7:0]       req8_s;

  for (genvar i = 0; i < N_CH; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn[i]),
      .press (press_s[i])
    );
  end

  assign req8_s     = 8'(pending_r);
  assign pick_s     = GW'(rr_next_grant(req8_s, 3'(rr_r), N_CH));
  assign pick_oh_s  = N_CH'(1'b1) << pick_s;
  assign grant_oh_s = N_CH'(1'b1) << grant_r;

  // Next-state, phase timing, light and request-latch decode.
  always_comb begin
    state_s = state_r;
    phase_s = phase_r;
    grant_s = grant_r;
    rr_s    = rr_r;
    clr_s   = {N_CH{1'b0}};
    walk_s  = {N_CH{1'b0}};
    flash_s = {N_CH{1'b0}};
    case (state_r)
      ST_IDLE: begin
        if ((|pending_r) && svc_ready) begin
          state_s = ST_WALK;
          grant_s = pick_s;
          phase_s = WALK_LOAD;
          clr_s   = pick_oh_s;
          walk_s  = pick_oh_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WALK: begin
        if (phase_r == CNT_ZERO) begin
          state_s = ST_FLASH;
          phase_s = FLASH_LOAD;
          flash_s = grant_oh_s;
        end else begin
          phase_s = phase_r - CNT_W'(1);
          walk_s  = grant_oh_s;
        end
      end
      ST_FLASH: begin
        if (phase_r == CNT_ZERO) begin
          state_s = ST_CLEAR;
        end else begin
          phase_s = phase_r - CNT_W'(1);
          flash_s = grant_oh_s;
        end
      end
      ST_CLEAR: begin
        rr_s    = grant_r;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // A press on the granting edge wins over the clear.
    pending_s = (pending_r & ~clr_s) | press_s;
    busy_s    = (state_s != ST_IDLE);
  end

  // State, arbitration and registered outputs; reset aborts any phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      phase_r   <= CNT_ZERO;
      grant_r   <= {GW{1'b0}};
      rr_r      <= GW'(N_CH - 1);
      pending_r <= {N_CH{1'b0}};
      walk_r    <= {N_CH{1'b0}};
      flash_r   <= {N_CH{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      phase_r   <= phase_s;
      grant_r   <= grant_s;
      rr_r      <= rr_s;
      pending_r <= pending_s;
      walk_r    <= walk_s;
      flash_r   <= flash_s;
      busy_r    <= busy_s;
    end
  end

  assign walk    = walk_r;
  assign flash   = flash_r;
  assign pending = pending_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_walk_request_ctrl.sv
// Scoreboard bench for walk_request_ctrl: a cycle-level behavioural model
// pushes the expected outputs for every clock edge; a monitor pops and
// compares them half a cycle later.
module tb_walk_request_ctrl;

  localparam int N_CH      = 2;
  localparam int DEBOUNCE  = 4;
  localparam int WALK_CYC  = 8;
  localparam int FLASH_CYC = 4;
  localparam int CNT_W     = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn = '0;
  logic            svc_ready = 1'b0;
  logic [N_CH-1:0] walk;
  logic [N_CH-1:0] flash;
  logic [N_CH-1:0] pending;
  logic            busy;

  walk_request_ctrl #(
    .N_CH      (N_CH),
    .DEBOUNCE  (DEBOUNCE),
    .WALK_CYC  (WALK_CYC),
    .FLASH_CYC (FLASH_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .svc_ready (svc_ready),
    .walk      (walk),
    .flash     (flash),
    .pending   (pending),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N_CH-1:0] walk;
    logic [N_CH-1:0] flash;
    logic [N_CH-1:0] pending;
    logic            busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: button delay line, run length of high synchronised
  // samples, pending set, phase position (-1 idle, then cycles since grant),
  // granted channel and last served channel.
  logic [N_CH-1:0] m_d1, m_d2, m_pend;
  int              m_run[N_CH];
  int              m_ph, m_g, m_rr;

  function automatic void model_step();
    exp_t            e;
    logic [N_CH-1:0] press;
    logic [N_CH-1:0] oh;
    press = '0;
    if (rst) begin
      m_d1 = '0;
      m_d2 = '0;
      for (int i = 0; i < N_CH; i++) m_run[i] = 0;
      m_ph   = -1;
      m_g    = 0;
      m_rr   = N_CH - 1;
      m_pend = '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        m_run[i] = m_d2[i] ? m_run[i] + 1 : 0;
        press[i] = (m_run[i] == DEBOUNCE);
        m_d2[i]  = m_d1[i];
        m_d1[i]  = btn[i];
      end
      if (m_ph < 0) begin
        if (m_pend != '0 && svc_ready) begin
          for (int k = 1; k <= N_CH; k++) begin
            int c;
            c = (m_rr + k) % N_CH;
            if (m_pend[c]) begin
              m_g = c;
              break;
            end
          end
          m_pend[m_g] = 1'b0;
          m_ph = 0;
        end
      end else if (m_ph == WALK_CYC + FLASH_CYC) begin
        m_rr = m_g;
        m_ph = -1;
      end else begin
        m_ph++;
      end
      m_pend = m_pend | press;
    end
    oh = '0;
    oh[m_g] = 1'b1;
    e.walk    = (m_ph >= 0 && m_ph < WALK_CYC) ? oh : '0;
    e.flash   = (m_ph >= WALK_CYC && m_ph < WALK_CYC + FLASH_CYC) ? oh : '0;
    e.pending = m_pend;
    e.busy    = (m_ph >= 0);
    exp_q.push_back(e);
  endfunction

  function automatic void check(input string name, input logic [7:0] act,
                                input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endfunction

  // Model advances on every active edge using the inputs the DUT sampled.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Monitor: compare each expected record against the settled DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("walk",    8'(walk),    8'(e.walk));
        check("flash",   8'(flash),   8'(e.flash));
        check("pending", 8'(pending), 8'(e.pending));
        check("busy",    8'(busy),    8'(e.busy));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_walk(input int ch, input int bound);
    int n;
    n = 0;
    while (walk[ch] !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (walk[ch] !== 1'b1) begin
      failures++;
      $display("FAIL wait_walk ch=%0d actual=timeout required=walk_high", ch);
    end
  endtask

  initial begin
    cycles(2);
    rst = 1'b0;
    svc_ready = 1'b1;

    // Single held press on channel 0: full walk/flash/clear cycle.
    btn = 2'b01;
    cycles(10);
    btn = 2'b00;
    cycles(20);

    // Short pulse and toggling on channel 1 never qualify as a press.
    btn = 2'b10;
    cycles(3);
    btn = 2'b00;
    cycles(10);
    for (int i = 0; i < 20; i++) begin
      btn[1] = ~btn[1];
      cycles(1);
    end
    btn = 2'b00;
    cycles(10);

    // Simultaneous requests, twice, to exercise round-robin order.
    btn = 2'b11;
    cycles(8);
    btn = 2'b00;
    cycles(40);
    btn = 2'b11;
    cycles(8);
    btn = 2'b00;
    cycles(40);

    // Request held off by svc_ready, then released.
    svc_ready = 1'b0;
    btn = 2'b01;
    cycles(8);
    btn = 2'b00;
    cycles(20);
    svc_ready = 1'b1;
    cycles(20);

    // Reset during the third WALK cycle of channel 1.
    btn = 2'b10;
    cycles(8);
    btn = 2'b00;
    wait_walk(1, 30);
    cycles(2);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    btn = 2'b11;
    cycles(8);
    btn = 2'b00;
    cycles(40);

    // Channel 0 presses again during its own WALK and is re-served.
    btn = 2'b01;
    cycles(6);
    btn = 2'b00;
    wait_walk(0, 30);
    btn = 2'b01;
    cycles(6);
    btn = 2'b00;
    cycles(40);

    // Randomised buttons, svc_ready and occasional reset.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
      end
      svc_ready = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 299) == 0);
      cycles(1);
    end
    rst = 1'b0;
    btn = '0;
    svc_ready = 1'b1;
    cycles(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
